idelay_sweep_ctrl: RTL and testbench
====================================

Name: idelay_sweep_ctrl

Overview:
- Sequencer for an ISERDES/IDELAY tap sweep.
- Steps the IDELAY tap value through 0..NUM_TAPS-1. For each tap it waits a settle period, then counts comparator error flags over a fixed window.
- Emits one result strobe per tap, then reports the centre of the longest error-free tap run as the recommended tap.
- Sits between the IDELAYE2 (VAR_LOAD mode) and the pattern comparator in the minitest top level.

Parameters:
- TAP_WIDTH, 5, width of the IDELAY tap value.
- NUM_TAPS, 32, number of taps swept (2..2^TAP_WIDTH).
- SETTLE_CYCLES, 16, idle cycles after each tap load before counting (>=1).
- WINDOW_CYCLES, 256, measurement window length in cycles (>=1).
- COUNT_WIDTH, 8, width of the per-tap error counter (saturating).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-low.
- I_START  in  1  start request; honoured only in IDLE.
- I_ERR  in  1  comparator error flag, sampled every MEASURE cycle.
- O_BUSY  out  1  high in every state except IDLE.
- O_DLY_LD  out  1  one-cycle load pulse to the IDELAY.
- O_DLY_CNT  out  TAP_WIDTH  tap value presented to the IDELAY.
- O_STB  out  1  per-tap result valid, one cycle.
- O_TAP  out  TAP_WIDTH  tap index of the result.
- O_CNT  out  COUNT_WIDTH  error count for O_TAP.
- O_DONE  out  1  sweep complete, one cycle.
- O_BEST_TAP  out  TAP_WIDTH  recommended tap.
- O_BEST_VALID  out  1  an error-free run exists.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, tap 0, run tracker cleared. When RST is low at an edge this overrides all other activity, including a sweep in progress.
- FSM states: IDLE, LOAD, SETTLE, MEASURE, REPORT, DONE.
- IDLE:
  - On I_START=1, go to LOAD with tap=0.
  - Clear O_BEST_VALID and the run tracker.
  - I_START in any other state is ignored.
- LOAD (1 cycle):
  - O_DLY_LD=1, O_DLY_CNT=tap.
  - Go to SETTLE.
  - O_DLY_CNT holds its value until the next LOAD.
- SETTLE (exactly SETTLE_CYCLES cycles): go to MEASURE.
- MEASURE (exactly WINDOW_CYCLES cycles):
  - The counter starts at 0 and adds I_ERR each cycle.
  - It saturates at 2^COUNT_WIDTH-1 and never wraps.
- REPORT (1 cycle):
  - O_STB=1, O_TAP=tap, O_CNT=count. O_TAP and O_CNT hold afterwards.
  - The run tracker updates.
  - If tap==NUM_TAPS-1, go to DONE; otherwise increment tap and go to LOAD.
- DONE (1 cycle):
  - O_DONE=1.
  - O_BEST_TAP and O_BEST_VALID are registered here and held until the next DONE (O_BEST_VALID is cleared at start).
  - Go to IDLE.
- Per-tap period is 2+SETTLE_CYCLES+WINDOW_CYCLES cycles. The first O_STB comes that many cycles after the start-accept edge.
- Run tracker:
  - A tap with count==0 extends the current run; it records run_start on the first zero tap.
  - A nonzero tap, or the last tap, closes the run.
  - On close, if run_len > best_len (strictly greater, so the earliest run wins ties), store it.
  - O_BEST_TAP = best_start + ((best_len-1)>>1).
  - With no zero-count tap: O_BEST_VALID=0 and O_BEST_TAP=0.
- Arithmetic: the tap counter, run length and run start are TAP_WIDTH+1 bits internally so NUM_TAPS=2^TAP_WIDTH is representable.

Optional Feature:
- Macro: IDELAY_SWEEP_ABORT_EN.
- Defined: adds input I_ABORT (1 bit).
  - I_ABORT=1 in any non-IDLE state forces IDLE on the next edge.
  - No O_STB and no O_DONE are issued; O_BEST_VALID=0.
  - O_DLY_CNT is kept at its last value.
- Undefined: no port; the sweep always runs to completion.

Decomposition:
- Package idelay_sweep_pkg:
  - FSM state enum (3-bit encoding).
  - Default parameter constants.
  - Helper function for centre-of-run computation.
- Sub-module eye_run_tracker:
  - Inputs: clear, update strobe, tap, zero flag, last flag.
  - Outputs: best_start, best_len, valid.
- Top FSM and window counters stay in idelay_sweep_ctrl.

Test Plan (NUM_TAPS=8, TAP_WIDTH=3, SETTLE_CYCLES=4, WINDOW_CYCLES=16, COUNT_WIDTH=4):
- I_ERR=0 for all taps -> 8 strobes with O_CNT=0 spaced 22 cycles apart, first 22 cycles after start accept; O_DONE, O_BEST_TAP=3, O_BEST_VALID=1.
- I_ERR=1 during taps 0,1,6,7, else 0 -> O_CNT=15,15,0,0,0,0,15,15; O_BEST_TAP=3.
- Zero-error taps exactly {1,2,5,6} -> tie between runs; O_BEST_TAP=1 (earliest run wins).
- I_ERR tied 1 -> every O_CNT=15 (saturated, no wrap); O_BEST_VALID=0, O_BEST_TAP=0.
- RST low during MEASURE of tap 4 -> next edge: all outputs 0, IDLE. I_START pulse during the sweep is ignored; a new start restarts at tap 0 with O_DLY_LD pulse.
- IDELAY_SWEEP_ABORT_EN defined, I_ABORT during SETTLE of tap 2 -> IDLE next edge; no further O_STB/O_DONE; O_DLY_CNT stays 2.

Source files
------------

// File: rtl/idelay_sweep_pkg.sv
// Shared types and constants for the IDELAY tap sweep sequencer.
// Contents: FSM state enum, default parameters, run-centre helper.
package idelay_sweep_pkg;

  localparam int DEF_TAP_WIDTH     = 5;
  localparam int DEF_NUM_TAPS      = 32;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_WINDOW_CYCLES = 256;
  localparam int DEF_COUNT_WIDTH   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_MEASURE,
    S_REPORT,
    S_DONE
  } state_t;

  function automatic logic [15:0] run_centre(
    input logic [16:0] start,
    input logic [16:0] len
  );
    logic [16:0] c;
    if (len == 17'd0) begin
      c = 17'd0;
    end else begin
      c = start + ((len - 17'd1) >> 1);
    end
    return c[15:0];
  endfunction

endpackage

// File: rtl/eye_run_tracker.sv
// Tracks the longest run of zero-error taps; earliest run wins ties.
// Ports: CLK, RST (sync, low), clr, upd, tap, zero, last -> best_start, best_len, valid.
module eye_run_tracker
  import idelay_sweep_pkg::*;
#(
  parameter int TAP_WIDTH = DEF_TAP_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clr,
  input  logic               upd,
  input  logic [TAP_WIDTH:0] tap,
  input  logic               zero,
  input  logic               last,
  output logic [TAP_WIDTH:0] best_start,
  output logic [TAP_WIDTH:0] best_len,
  output logic               valid
);

  localparam int W = TAP_WIDTH + 1;

  logic [TAP_WIDTH:0] cur_len;
  logic [TAP_WIDTH:0] cur_start;
  logic [TAP_WIDTH:0] run_len;
  logic [TAP_WIDTH:0] run_st;
  logic               close;

  // Candidate run including this tap (or the open run on a nonzero tap).
  always_comb begin
    run_len = cur_len;
    run_st  = cur_start;
    if (zero) begin
      run_len = cur_len + W'(1);
      if (cur_len == '0) begin
        run_st = tap;
      end
    end
  end

  assign close = !zero || last;
  assign valid = (best_len != '0);

  always_ff @(posedge CLK) begin
    if (!RST || clr) begin
      cur_len    <= '0;
      cur_start  <= '0;
      best_len   <= '0;
      best_start <= '0;
    end else if (upd) begin
      if (close) begin
        cur_len <= '0;
        if (run_len > best_len) begin
          best_len   <= run_len;
          best_start <= run_st;
        end
      end else begin
        cur_len   <= run_len;
        cur_start <= run_st;
      end
    end
  end

endmodule

// File: rtl/idelay_sweep_ctrl.sv
// IDELAY tap sweep: load, settle, count errors per tap, report best centre.
// Ports: CLK, RST, I_START, I_ERR, [I_ABORT if IDELAY_SWEEP_ABORT_EN] -> O_* status/results.
module idelay_sweep_ctrl
  import idelay_sweep_pkg::*;
#(
  parameter int TAP_WIDTH     = DEF_TAP_WIDTH,
  parameter int NUM_TAPS      = DEF_NUM_TAPS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   I_START,
  input  logic                   I_ERR,
`ifdef IDELAY_SWEEP_ABORT_EN
  input  logic                   I_ABORT,
`endif
  output logic                   O_BUSY,
  output logic                   O_DLY_LD,
  output logic [TAP_WIDTH-1:0]   O_DLY_CNT,
  output logic                   O_STB,
  output logic [TAP_WIDTH-1:0]   O_TAP,
  output logic [COUNT_WIDTH-1:0] O_CNT,
  output logic                   O_DONE,
  output logic [TAP_WIDTH-1:0]   O_BEST_TAP,
  output logic                   O_BEST_VALID
);

  localparam int TW1   = TAP_WIDTH + 1;
  localparam int CMAX  = (SETTLE_CYCLES > WINDOW_CYCLES) ?
                         SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CYC_W = $clog2(CMAX + 1);

  state_t                 state;
  logic [TAP_WIDTH:0]     tap;
  logic [CYC_W-1:0]       cyc;
  logic [COUNT_WIDTH-1:0] err_cnt;
  logic                   abort_req;
  logic                   last_tap;
  logic [TAP_WIDTH:0]     b_start;
  logic [TAP_WIDTH:0]     b_len;
  logic                   b_valid;

`ifdef IDELAY_SWEEP_ABORT_EN
  assign abort_req = I_ABORT;
`else
  assign abort_req = 1'b0;
`endif

  assign O_BUSY   = (state != S_IDLE);
  assign last_tap = (tap == TW1'(NUM_TAPS - 1));

  eye_run_tracker #(
    .TAP_WIDTH (TAP_WIDTH)
  ) u_trk (
    .CLK        (CLK),
    .RST        (RST),
    .clr        (state == S_IDLE),
    .upd        (state == S_REPORT),
    .tap        (tap),
    .zero       (err_cnt == '0),
    .last       (last_tap),
    .best_start (b_start),
    .best_len   (b_len),
    .valid      (b_valid)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= S_IDLE;
      tap          <= '0;
      cyc          <= '0;
      err_cnt      <= '0;
      O_DLY_LD     <= 1'b0;
      O_DLY_CNT    <= '0;
      O_STB        <= 1'b0;
      O_TAP        <= '0;
      O_CNT        <= '0;
      O_DONE       <= 1'b0;
      O_BEST_TAP   <= '0;
      O_BEST_VALID <= 1'b0;
    end else if (abort_req && state != S_IDLE) begin
      state        <= S_IDLE;
      O_DLY_LD     <= 1'b0;
      O_STB        <= 1'b0;
      O_DONE       <= 1'b0;
      O_BEST_VALID <= 1'b0;
    end else begin
      O_DLY_LD <= 1'b0;
      O_STB    <= 1'b0;
      O_DONE   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (I_START) begin
            state        <= S_LOAD;
            tap          <= '0;
            O_BEST_VALID <= 1'b0;
          end
        end
        S_LOAD: begin
          O_DLY_LD  <= 1'b1;
          O_DLY_CNT <= tap[TAP_WIDTH-1:0];
          cyc       <= '0;
          state     <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cyc == CYC_W'(SETTLE_CYCLES - 1)) begin
            cyc     <= '0;
            err_cnt <= '0;
            state   <= S_MEASURE;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        S_MEASURE: begin
          if (I_ERR && err_cnt != '1) begin
            err_cnt <= err_cnt + COUNT_WIDTH'(1);
          end
          if (cyc == CYC_W'(WINDOW_CYCLES - 1)) begin
            state <= S_REPORT;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        S_REPORT: begin
          O_STB <= 1'b1;
          O_TAP <= tap[TAP_WIDTH-1:0];
          O_CNT <= err_cnt;
          if (last_tap) begin
            state <= S_DONE;
          end else begin
            tap   <= tap + TW1'(1);
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          O_DONE       <= 1'b1;
          O_BEST_TAP   <= TAP_WIDTH'(run_centre(17'(b_start), 17'(b_len)));
          O_BEST_VALID <= b_valid;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idelay_sweep_ctrl.sv
// Scoreboard bench for idelay_sweep_ctrl (8 taps, settle 4, window 16).
// Define IDELAY_SWEEP_ABORT_EN to also exercise the abort input.
module tb_idelay_sweep_ctrl;

  localparam int TW  = 3;
  localparam int NT  = 8;
  localparam int SC  = 4;
  localparam int WC  = 16;
  localparam int CW  = 4;
  localparam int PER = 2 + SC + WC;

  typedef struct {
    int tap;
    int cnt;
    int cyc;
  } stb_t;

  typedef struct {
    int tap;
    int v;
    int cyc;
  } done_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          I_START;
  logic          I_ERR;
`ifdef IDELAY_SWEEP_ABORT_EN
  logic          I_ABORT;
`endif
  logic          O_BUSY;
  logic          O_DLY_LD;
  logic [TW-1:0] O_DLY_CNT;
  logic          O_STB;
  logic [TW-1:0] O_TAP;
  logic [CW-1:0] O_CNT;
  logic          O_DONE;
  logic [TW-1:0] O_BEST_TAP;
  logic          O_BEST_VALID;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc   = -1000;
  int mode  = 0;
  logic [7:0] mask = 8'h00;

  stb_t  stbq[$];
  done_t doneq[$];

  idelay_sweep_ctrl #(
    .TAP_WIDTH     (TW),
    .NUM_TAPS      (NT),
    .SETTLE_CYCLES (SC),
    .WINDOW_CYCLES (WC),
    .COUNT_WIDTH   (CW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .I_START      (I_START),
    .I_ERR        (I_ERR),
`ifdef IDELAY_SWEEP_ABORT_EN
    .I_ABORT      (I_ABORT),
`endif
    .O_BUSY       (O_BUSY),
    .O_DLY_LD     (O_DLY_LD),
    .O_DLY_CNT    (O_DLY_CNT),
    .O_STB        (O_STB),
    .O_TAP        (O_TAP),
    .O_CNT        (O_CNT),
    .O_DONE       (O_DONE),
    .O_BEST_TAP   (O_BEST_TAP),
    .O_BEST_VALID (O_BEST_VALID)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Error stimulus: mode 0 follows a per-tap mask on the loaded tap;
  // mode 1 raises I_ERR through settle and the first 2*k window cycles.
  always @(negedge CLK) begin
    int rel;
    int p;
    int k;
    if (mode == 0) begin
      I_ERR = mask[O_DLY_CNT];
    end else begin
      rel = cyc - acc;
      p = rel % PER;
      k = rel / PER;
      I_ERR = (rel >= 0) && (p >= 1) && (p < 1 + SC + 2 * k);
    end
  end

  always @(negedge CLK) begin
    stb_t  e;
    done_t d;
    if (O_STB) begin
      if (stbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_stb: tap %0d at cycle %0d", O_TAP, cyc);
      end else begin
        e = stbq.pop_front();
        chk("stb_tap", int'(O_TAP), e.tap);
        chk("stb_cnt", int'(O_CNT), e.cnt);
        chk("stb_cycle", cyc, e.cyc);
      end
    end
    if (O_DONE) begin
      if (doneq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        d = doneq.pop_front();
        chk("best_tap", int'(O_BEST_TAP), d.tap);
        chk("best_valid", int'(O_BEST_VALID), d.v);
        chk("done_cycle", cyc, d.cyc);
      end
    end
  end

  task automatic start_sweep(input int n_stb, input bit with_done,
                             input int btap, input int bval);
    stb_t  e;
    done_t d;
    I_START = 1'b1;
    acc = cyc + 1;
    for (int k = 0; k < n_stb; k++) begin
      e.tap = k;
      e.cnt = (mode == 0) ? (mask[k] ? 15 : 0) : 2 * k;
      e.cyc = acc + PER * (k + 1);
      stbq.push_back(e);
    end
    if (with_done) begin
      d.tap = btap;
      d.v   = bval;
      d.cyc = acc + PER * NT + 1;
      doneq.push_back(d);
    end
    @(negedge CLK);
    I_START = 1'b0;
    chk("busy_after_start", int'(O_BUSY), 1);
    @(negedge CLK);
    chk("dly_ld_pulse", int'(O_DLY_LD), 1);
    chk("dly_cnt_tap0", int'(O_DLY_CNT), 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((stbq.size() != 0 || doneq.size() != 0) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (stbq.size() != 0 || doneq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d strobes, %0d done pending",
               stbq.size(), doneq.size());
      stbq.delete();
      doneq.delete();
    end
    repeat (2) @(negedge CLK);
    chk("idle_after_done", int'(O_BUSY), 0);
  endtask

  task automatic chk_all_zero();
    chk("rst_busy", int'(O_BUSY), 0);
    chk("rst_dly_ld", int'(O_DLY_LD), 0);
    chk("rst_dly_cnt", int'(O_DLY_CNT), 0);
    chk("rst_stb", int'(O_STB), 0);
    chk("rst_tap", int'(O_TAP), 0);
    chk("rst_cnt", int'(O_CNT), 0);
    chk("rst_done", int'(O_DONE), 0);
    chk("rst_best_tap", int'(O_BEST_TAP), 0);
    chk("rst_best_valid", int'(O_BEST_VALID), 0);
  endtask

  initial begin
    RST = 1'b0;
    I_START = 1'b0;
    I_ERR = 1'b0;
`ifdef IDELAY_SWEEP_ABORT_EN
    I_ABORT = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    chk_all_zero();
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    mode = 0; mask = 8'h00;
    start_sweep(NT, 1'b1, 3, 1);
    wait_drain();
    chk("best_tap_hold", int'(O_BEST_TAP), 3);

    mode = 0; mask = 8'hFF;
    start_sweep(NT, 1'b1, 0, 0);
    wait_drain();

    mode = 1;
    start_sweep(NT, 1'b1, 0, 1);
    wait_drain();

    mode = 0; mask = 8'b1100_0011;
    start_sweep(NT, 1'b1, 3, 1);
    wait_drain();

    mode = 0; mask = 8'b1001_1001;
    start_sweep(NT, 1'b1, 1, 1);
    wait_drain();
    chk("best_valid_hold", int'(O_BEST_VALID), 1);

    mode = 0; mask = 8'h00;
    start_sweep(4, 1'b0, 0, 0);
    while (cyc < acc + 30) @(negedge CLK);
    I_START = 1'b1;
    @(negedge CLK);
    I_START = 1'b0;
    while (cyc < acc + 4 * PER + 10) @(negedge CLK);
    chk("pre_rst_dly_cnt", int'(O_DLY_CNT), 4);
    RST = 1'b0;
    @(negedge CLK);
    chk_all_zero();
    chk("rst_pending_stb", stbq.size(), 0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    start_sweep(NT, 1'b1, 3, 1);
    wait_drain();

`ifdef IDELAY_SWEEP_ABORT_EN
    mode = 0; mask = 8'h00;
    start_sweep(2, 1'b0, 0, 0);
    while (cyc < acc + 2 * PER + 2) @(negedge CLK);
    I_ABORT = 1'b1;
    @(negedge CLK);
    I_ABORT = 1'b0;
    chk("abort_busy", int'(O_BUSY), 0);
    chk("abort_dly_cnt", int'(O_DLY_CNT), 2);
    chk("abort_best_valid", int'(O_BEST_VALID), 0);
    repeat (3 * PER) @(negedge CLK);
    chk("abort_still_idle", int'(O_BUSY), 0);
    chk("abort_dly_cnt_kept", int'(O_DLY_CNT), 2);
    chk("abort_pending_stb", stbq.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
